// File: rtl/fm_spy_readout_if.sv
// Request and output-stream bundle for the spy read-out sequencer.
// Request side: valid/ready handshake, accepted only while the sequencer idles.
// Stream side: valid/ready, word pops on out_valid & out_ready.
interface fm_spy_readout_if #(
  parameter int SB_N   = 29,
  parameter int AXI_DW = 32,
  parameter int ADDR_W = 16
);
  localparam int SEL_W = (SB_N > 1) ? $clog2(SB_N) : 1;

  logic              req_valid;
  logic              req_ready;
  logic [SEL_W-1:0]  req_sb_sel;
  logic [ADDR_W-1:0] req_start_addr;
  logic [ADDR_W-1:0] req_len;
  logic [ADDR_W-1:0] req_addr_mask;

  logic              out_valid;
  logic              out_ready;
  logic [AXI_DW-1:0] out_data;
  logic              out_last;

  modport master (
    output req_valid, req_sb_sel, req_start_addr, req_len, req_addr_mask, out_ready,
    input  req_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  req_valid, req_sb_sel, req_start_addr, req_len, req_addr_mask, out_ready,
    output req_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fm_spy_readout.sv
// Block-read sequencer: drives one spy buffer's spy_en/spy_addr and streams the read words out.
// Latency: accept -> first spy_en 1 cycle; spy_en -> out_valid 2 cycles (capture + FIFO).
// Backpressure: credit-limited issue keeps FIFO from overflowing; optional checksum via FM_SPY_READOUT_CHECKSUM_EN.
module fm_spy_readout #(
  parameter int SB_N       = 29,
  parameter int AXI_DW     = 32,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   spy_clock,
  input  logic                   axi_reset_n,
  fm_spy_readout_if.slave        bus,
  input  logic                   abort,
  output logic [SB_N-1:0]        spy_en,
  output logic [ADDR_W-1:0]      spy_addr,
  input  logic [SB_N*AXI_DW-1:0] spy_data_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err_sel
);

  localparam int SEL_W = (SB_N > 1) ? $clog2(SB_N) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [SEL_W:0] SB_N_L  = (SEL_W+1)'(SB_N);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [AXI_DW-1:0]     fdat_q [FIFO_DEPTH];
  logic [AXI_DW-1:0]     fdat_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] flast_q, flast_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

`ifdef FM_SPY_READOUT_CHECKSUM_EN
  logic [AXI_DW-1:0] csum_q, csum_d;
  logic              csum_pend_q, csum_pend_d;
  logic              csum_push;
`endif

  logic              accept;
  logic              credit;
  logic              issue;
  logic              last_issue;
  logic              flush;
  logic              data_push;
  logic              push;
  logic              pop;
  logic [AXI_DW-1:0] push_dat;
  logic              push_last;
  logic [AXI_DW-1:0] cap_data;
  logic [CNT_W:0]    occ;

  assign accept     = (state_q == S_IDLE) && bus.req_valid;
  assign flush      = abort && (state_q != S_IDLE);
  assign occ        = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit     = occ < DEPTH_L;
  // Issue is combinational on abort so the read enable drops in the abort cycle itself.
  assign issue      = (state_q == S_ISSUE) && credit && !abort;
  assign last_issue = (rem_q == ADDR_W'(1));
  assign data_push  = inflight_q && !flush;
  assign pop        = (cnt_q != '0) && bus.out_ready;

  // Select the returning read word from the buffer latched at request time.
  always_comb begin
    cap_data = '0;
    for (int i = 0; i < SB_N; i++) begin
      if (sel_q == SEL_W'(i)) cap_data = spy_data_in[i*AXI_DW +: AXI_DW];
    end
  end

  // One-hot read enable; spy_addr is the registered current address.
  always_comb begin
    spy_en = '0;
    for (int i = 0; i < SB_N; i++) begin
      spy_en[i] = issue && (sel_q == SEL_W'(i));
    end
  end

  // FIFO write mux: data capture, or the checksum word once all data is in.
  always_comb begin
`ifdef FM_SPY_READOUT_CHECKSUM_EN
    csum_push = csum_pend_q && !inflight_q && (state_q == S_DRAIN) &&
                (cnt_q < CNT_W'(FIFO_DEPTH)) && !flush;
    push      = data_push || csum_push;
    push_dat  = csum_push ? csum_q : cap_data;
    push_last = csum_push;
`else
    push      = data_push;
    push_dat  = cap_data;
    push_last = infl_last_q;
`endif
  end

  // FIFO next state; abort empties it so out_valid drops the following cycle.
  always_comb begin
    fdat_d   = fdat_q;
    flast_d  = flast_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        fdat_d[wr_ptr_q]  = push_dat;
        flast_d[wr_ptr_q] = push_last;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Sequencer next state: request latch, address walk, drain and completion.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    rem_d       = rem_q;
    err_d       = err_q;
    inflight_d  = issue;
    infl_last_d = issue && last_issue;
`ifdef FM_SPY_READOUT_CHECKSUM_EN
    csum_d      = csum_q;
    csum_pend_d = csum_pend_q;
    if (data_push) begin
      csum_d = csum_q ^ cap_data;
      if (infl_last_q) csum_pend_d = 1'b1;
    end
    if (csum_push) csum_pend_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sel_d  = bus.req_sb_sel;
          addr_d = bus.req_start_addr & bus.req_addr_mask;
          mask_d = bus.req_addr_mask;
          rem_d  = bus.req_len;
          err_d  = 1'b0;
`ifdef FM_SPY_READOUT_CHECKSUM_EN
          csum_d = '0;
`endif
          if ({1'b0, bus.req_sb_sel} >= SB_N_L) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else if (bus.req_len == '0) begin
`ifdef FM_SPY_READOUT_CHECKSUM_EN
            // Empty transfer still delivers its (zero) checksum word.
            csum_pend_d = 1'b1;
            state_d     = S_DRAIN;
`else
            state_d = S_FINISH;
`endif
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if (issue) begin
          addr_d = (addr_q + ADDR_W'(1)) & mask_q;
          rem_d  = rem_q - ADDR_W'(1);
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_FINISH;
`ifdef FM_SPY_READOUT_CHECKSUM_EN
        end else if (cnt_d == '0 && !inflight_d && !csum_pend_d) begin
`else
        end else if (cnt_d == '0 && !inflight_d) begin
`endif
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`ifdef FM_SPY_READOUT_CHECKSUM_EN
    if (flush) csum_pend_d = 1'b0;
`endif
    // done is high exactly for the FINISH cycle.
    done_d = (state_d == S_FINISH);
  end

  // All state registers; asynchronous reset returns to IDLE with an empty FIFO.
  always_ff @(posedge spy_clock or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      mask_q      <= '0;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fdat_q[i] <= '0;
      flast_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
`ifdef FM_SPY_READOUT_CHECKSUM_EN
      csum_q      <= '0;
      csum_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      rem_q       <= rem_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      err_q       <= err_d;
      done_q      <= done_d;
      fdat_q      <= fdat_d;
      flast_q     <= flast_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
`ifdef FM_SPY_READOUT_CHECKSUM_EN
      csum_q      <= csum_d;
      csum_pend_q <= csum_pend_d;
`endif
    end
  end

  assign spy_addr      = addr_q;
  assign bus.req_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err_sel       = err_q;
  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_data  = fdat_q[rd_ptr_q];
  assign bus.out_last  = flast_q[rd_ptr_q];

endmodule
